// File: rtl/reg_file.sv
// reg_file: NREG x XLEN register file with two combinational read ports,
// one write port and same-cycle write-to-read bypass. x0 is hardwired to
// zero; reset is synchronous and active-high and clears every register.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    // Address bits that actually select a stored register.
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] wsel_s;
    logic            byp_en_s;
    logic [XLEN-1:0] stored1_s;
    logic [XLEN-1:0] stored2_s;

    // One-hot write select; x0 and indices beyond NREG never get a bit.
    function automatic logic [NREG-1:0] decode_onehot(
        input logic [4:0] idx,
        input logic       en
    );
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 1; i < NREG; i++) begin
            if (en && (idx == 5'(i))) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Read mux for one port: zero for x0 / out-of-range, bypass, else stored.
    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] stored,
        input logic            byp,
        input logic [4:0]      widx,
        input logic [XLEN-1:0] wdata
    );
        logic [XLEN-1:0] v;
        if ((idx == 5'd0) || (int'(idx) >= NREG)) begin
            v = '0;
        end else if (byp && (idx == widx)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Decode the write port; reset suppresses both the write and the bypass.
    always_comb begin
        wsel_s = decode_onehot(rd, we & ~rst);
        if (we && !rst && (rd != 5'd0)) begin
            byp_en_s = 1'b1;
        end else begin
            byp_en_s = 1'b0;
        end
    end

    // Next-state contents: only the selected register takes wd, x0 stays zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (wsel_s[i]) begin
                regs_d[i] = wd;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        regs_d[0] = '0;
    end

    // Register storage with synchronous clear that overrides any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational read ports with independent per-port bypass.
    always_comb begin
        stored1_s = regs_q[rs1[AW-1:0]];
        stored2_s = regs_q[rs2[AW-1:0]];
        rd1       = read_port(rs1, stored1_s, byp_en_s, rd, wd);
        rd2       = read_port(rs2, stored2_s, byp_en_s, rd, wd);
    end

endmodule
